// File: rtl/panic_dma_tx.sv
// Store-and-forward DMA-to-crossbar framer: buffers one packet, then emits a descriptor header beat and the payload.
// Optional macro PANIC_DMA_TX_TIMESTAMP_EN stamps the header TS field with the timestamp input.

`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 32
`endif
`ifndef PANIC_DESC_PORT_OF
`define PANIC_DESC_PORT_OF 2:0
`endif
`ifndef PANIC_DESC_CELL_ID_OF
`define PANIC_DESC_CELL_ID_OF 10:3
`endif
`ifndef PANIC_DESC_FLOW_OF
`define PANIC_DESC_FLOW_OF 15:11
`endif
`ifndef PANIC_DESC_LEN_OF
`define PANIC_DESC_LEN_OF 31:16
`endif
`ifndef PANIC_DESC_TS_OF
`define PANIC_DESC_TS_OF 63:32
`endif

module panic_dma_tx #(
    parameter int AXIS_DATA_WIDTH   = 512,
    parameter int AXIS_KEEP_WIDTH   = AXIS_DATA_WIDTH / 8,
    parameter int SWITCH_DEST_WIDTH = 3,
    parameter int SWITCH_USER_WIDTH = 1,
    parameter int BUF_DEPTH         = 32
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [AXIS_DATA_WIDTH-1:0]     s_tx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]     s_tx_axis_tkeep,
    input  logic                           s_tx_axis_tvalid,
    output logic                           s_tx_axis_tready,
    input  logic                           s_tx_axis_tlast,
    input  logic [15:0]                    s_tx_axis_tdest,
    input  logic [SWITCH_DEST_WIDTH-1:0]   sched_dest,

    output logic [AXIS_DATA_WIDTH-1:0]     m_switch_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]     m_switch_axis_tkeep,
    output logic                           m_switch_axis_tvalid,
    input  logic                           m_switch_axis_tready,
    output logic                           m_switch_axis_tlast,
    output logic [SWITCH_DEST_WIDTH-1:0]   m_switch_axis_tdest,
    output logic [SWITCH_USER_WIDTH-1:0]   m_switch_axis_tuser,

    input  logic [`PANIC_DESC_TS_SIZE-1:0] timestamp,
    output logic [15:0]                    drop_count
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RECV    = 3'd1;
    localparam logic [2:0] ST_DROP    = 3'd2;
    localparam logic [2:0] ST_HDR     = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;

    logic [2:0]                   state_q, state_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [15:0]                  len_q, len_d;
    logic [4:0]                   flow_q, flow_d;
    logic [SWITCH_DEST_WIDTH-1:0] dest_q, dest_d;
    logic [15:0]                  drop_count_q, drop_count_d;
    logic                         s_ready_q, s_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic [AXIS_DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [AXIS_KEEP_WIDTH-1:0]   out_keep_q, out_keep_d;

    logic [AXIS_DATA_WIDTH-1:0]   mem_data_q [BUF_DEPTH];
    logic [AXIS_KEEP_WIDTH-1:0]   mem_keep_q [BUF_DEPTH];

    logic                         mem_we_c;
    logic                         s_fire_c;
    logic                         buf_full_c;
    logic [4:0]                   flow_in_c;
    logic [15:0]                  len_sum_c;
    logic [15:0]                  drop_inc_c;
    logic [AXIS_DATA_WIDTH-1:0]   hdr_c;
    logic [IDX_W-1:0]             rd_idx_c;
    logic                         unused_inputs_c;

    // Number of valid bytes in a beat.
    function automatic logic [15:0] keep_bytes(input logic [AXIS_KEEP_WIDTH-1:0] k);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
            n = n + 16'(k[i]);
        end
        return n;
    endfunction

    assign s_fire_c   = s_tx_axis_tvalid & s_ready_q;
    assign buf_full_c = (wr_ptr_q == PTR_W'(BUF_DEPTH));
    assign flow_in_c  = (state_q == ST_IDLE) ? s_tx_axis_tdest[4:0] : flow_q;
    assign len_sum_c  = len_q + keep_bytes(s_tx_axis_tkeep);
    assign drop_inc_c = (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;
    assign rd_idx_c   = rd_ptr_q[IDX_W-1:0];

    // Header is assembled from the values in force when the last input beat is accepted.
    always_comb begin
        hdr_c = '0;
        hdr_c[`PANIC_DESC_PORT_OF]    = '0;
        hdr_c[`PANIC_DESC_CELL_ID_OF] = '0;
        hdr_c[`PANIC_DESC_FLOW_OF]    = flow_in_c;
        hdr_c[`PANIC_DESC_LEN_OF]     = len_sum_c;
`ifdef PANIC_DMA_TX_TIMESTAMP_EN
        hdr_c[`PANIC_DESC_TS_OF]      = timestamp;
`else
        hdr_c[`PANIC_DESC_TS_OF]      = '0;
`endif
    end

`ifdef PANIC_DMA_TX_TIMESTAMP_EN
    assign unused_inputs_c = ^s_tx_axis_tdest[15:5];
`else
    assign unused_inputs_c = ^{s_tx_axis_tdest[15:5], timestamp};
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        flow_d       = flow_q;
        dest_d       = dest_q;
        drop_count_d = drop_count_q;
        s_ready_d    = s_ready_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        mem_we_c     = 1'b0;

        case (state_q)
            ST_IDLE, ST_RECV: begin
                if (s_fire_c) begin
                    if (state_q == ST_IDLE) begin
                        flow_d = flow_in_c;
                        dest_d = sched_dest;
                    end
                    if (buf_full_c) begin
                        // Packet longer than the buffer: discard the rest of it.
                        if (s_tx_axis_tlast) begin
                            state_d      = ST_IDLE;
                            wr_ptr_d     = '0;
                            len_d        = '0;
                            drop_count_d = drop_inc_c;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        mem_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        len_d    = len_sum_c;
                        if (s_tx_axis_tlast) begin
                            state_d     = ST_HDR;
                            s_ready_d   = 1'b0;
                            out_valid_d = 1'b1;
                            out_data_d  = hdr_c;
                            out_keep_d  = '1;
                            out_last_d  = 1'b0;
                        end else begin
                            state_d = ST_RECV;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_fire_c && s_tx_axis_tlast) begin
                    state_d      = ST_IDLE;
                    wr_ptr_d     = '0;
                    len_d        = '0;
                    drop_count_d = drop_inc_c;
                end
            end
            ST_HDR, ST_PAYLOAD: begin
                if (m_switch_axis_tready) begin
                    if (state_q == ST_PAYLOAD && out_last_q) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        s_ready_d   = 1'b1;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        len_d       = '0;
                    end else begin
                        state_d    = ST_PAYLOAD;
                        out_data_d = mem_data_q[rd_idx_c];
                        out_keep_d = mem_keep_q[rd_idx_c];
                        out_last_d = (rd_ptr_q + PTR_W'(1) == wr_ptr_q);
                        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            flow_q       <= '0;
            dest_q       <= '0;
            drop_count_q <= '0;
            s_ready_q    <= 1'b1;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            flow_q       <= flow_d;
            dest_q       <= dest_d;
            drop_count_q <= drop_count_d;
            s_ready_q    <= s_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
        end
    end

    // Packet buffer storage; contents are only meaningful below wr_ptr_q.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_data_q[wr_ptr_q[IDX_W-1:0]] <= s_tx_axis_tdata;
            mem_keep_q[wr_ptr_q[IDX_W-1:0]] <= s_tx_axis_tkeep;
        end
    end

    assign s_tx_axis_tready     = s_ready_q;
    assign m_switch_axis_tdata  = out_data_q;
    assign m_switch_axis_tkeep  = out_keep_q;
    assign m_switch_axis_tvalid = out_valid_q;
    assign m_switch_axis_tlast  = out_last_q;
    assign m_switch_axis_tdest  = dest_q;
    assign m_switch_axis_tuser  = SWITCH_USER_WIDTH'(1);
    assign drop_count           = drop_count_q;

endmodule

// File: tb/tb_panic_dma_tx.sv
// Randomized bench for panic_dma_tx against a packet-level scoreboard model.
module tb_panic_dma_tx;

    localparam int DW    = 512;
    localparam int KW    = 64;
    localparam int DESTW = 3;
    localparam int USERW = 1;
    localparam int DEPTH = 4;

    // Header field positions in the descriptor beat.
    localparam int FLOW_LO = 11;
    localparam int LEN_LO  = 16;
    localparam int TS_LO   = 32;

    logic             clk;
    logic             rst;
    logic [DW-1:0]    s_tdata;
    logic [KW-1:0]    s_tkeep;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [15:0]      s_tdest;
    logic [DESTW-1:0] sched_dest;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [DESTW-1:0] m_tdest;
    logic [USERW-1:0] m_tuser;
    logic [31:0]      timestamp;
    logic [15:0]      drop_count;

    panic_dma_tx #(
        .AXIS_DATA_WIDTH(DW),
        .AXIS_KEEP_WIDTH(KW),
        .SWITCH_DEST_WIDTH(DESTW),
        .SWITCH_USER_WIDTH(USERW),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_tx_axis_tdata(s_tdata),
        .s_tx_axis_tkeep(s_tkeep),
        .s_tx_axis_tvalid(s_tvalid),
        .s_tx_axis_tready(s_tready),
        .s_tx_axis_tlast(s_tlast),
        .s_tx_axis_tdest(s_tdest),
        .sched_dest(sched_dest),
        .m_switch_axis_tdata(m_tdata),
        .m_switch_axis_tkeep(m_tkeep),
        .m_switch_axis_tvalid(m_tvalid),
        .m_switch_axis_tready(m_tready),
        .m_switch_axis_tlast(m_tlast),
        .m_switch_axis_tdest(m_tdest),
        .m_switch_axis_tuser(m_tuser),
        .timestamp(timestamp),
        .drop_count(drop_count)
    );

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [KW-1:0]    keep;
        logic             last;
        logic [DESTW-1:0] dest;
    } beat_t;

    beat_t       exp_q[$];
    logic [KW-1:0] keep_src[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          model_drops = 0;
    int          rdy_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [KW-1:0] rand_keep();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return {$urandom, $urandom};
    endfunction

    // Output-side backpressure pattern.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Collector: every output handshake is matched against the scoreboard; stalled beats must hold.
    initial begin
        logic          stalled;
        beat_t         held;
        beat_t         e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", DW'(m_tvalid), DW'(1));
                    check("stall_data", m_tdata, held.data);
                    check("stall_keep", DW'(m_tkeep), DW'(held.keep));
                    check("stall_last", DW'(m_tlast), DW'(held.last));
                    check("stall_dest", DW'(m_tdest), DW'(held.dest));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", DW'(1), DW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_tdata, e.data);
                        check("out_keep", DW'(m_tkeep), DW'(e.keep));
                        check("out_last", DW'(m_tlast), DW'(e.last));
                        check("out_dest", DW'(m_tdest), DW'(e.dest));
                        check("out_user", DW'(m_tuser), DW'(1));
                    end
                end
                stalled = m_tvalid && !m_tready;
                held = '{data: m_tdata, keep: m_tkeep, last: m_tlast, dest: m_tdest};
            end
        end
    end

    // Sends the packet described by keep_src; nsend < size models an aborted packet.
    task automatic send_pkt(input logic [4:0] flow, input logic [DESTW-1:0] sd,
                            input logic [31:0] ts, input int nsend);
        int            n;
        int            len;
        int            t;
        bit            ok;
        logic [DW-1:0] dat[$];
        logic [DW-1:0] hdr;
        n = keep_src.size();
        len = 0;
        for (int i = 0; i < n; i++) begin
            dat.push_back(rand_data());
            len += $countones(keep_src[i]);
        end
        if (nsend == n) begin
            if (n > DEPTH) begin
                model_drops++;
            end else begin
                hdr = '0;
                hdr[FLOW_LO +: 5] = flow;
                hdr[LEN_LO +: 16] = 16'(len);
`ifdef PANIC_DMA_TX_TIMESTAMP_EN
                hdr[TS_LO +: 32] = ts;
`endif
                exp_q.push_back('{data: hdr, keep: '1, last: 1'b0, dest: sd});
                for (int i = 0; i < n; i++)
                    exp_q.push_back('{data: dat[i], keep: keep_src[i], last: (i == n - 1), dest: sd});
            end
        end
        timestamp = ts;
        for (int i = 0; i < nsend; i++) begin
            s_tdata    = dat[i];
            s_tkeep    = keep_src[i];
            s_tlast    = (i == n - 1);
            s_tvalid   = 1'b1;
            s_tdest    = {11'($urandom), (i == 0) ? flow : 5'($urandom)};
            sched_dest = (i == 0) ? sd : DESTW'($urandom);
            ok = 1'b0;
            t = 0;
            while (!ok && t < 200) begin
                @(negedge clk);
                ok = s_tready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!ok) check("accept_timeout", DW'(1), DW'(0));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (nsend == n && n <= DEPTH) begin
            @(negedge clk);
            check("hdr_valid_latency", DW'(m_tvalid), DW'(1));
            check("s_tready_busy", DW'(s_tready), DW'(0));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", DW'(exp_q.size()), DW'(0));
            exp_q.delete();
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("drop_count", DW'(drop_count), DW'(model_drops));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int nb;
        rst = 1'b1;
        s_tdata = '0;
        s_tkeep = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdest = '0;
        sched_dest = '0;
        timestamp = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", DW'(m_tvalid), DW'(0));
        check("rst_tready", DW'(s_tready), DW'(1));
        check("rst_drop_count", DW'(drop_count), DW'(0));
        @(posedge clk);
        #1;

        // Three beats, 64+64+4 bytes.
        keep_src = {'1, '1, 64'h0F};
        send_pkt(5'd5, 3'd2, 32'd77, 3);
        drain();

        // Single beat with one byte.
        keep_src = {64'h1};
        send_pkt(5'd9, 3'd6, 32'd5, 1);
        drain();

        // Oversize packets: six beats, then five beats ending exactly past the buffer.
        keep_src = {'1, '1, '1, '1, '1, '1};
        send_pkt(5'd3, 3'd1, 32'd9, 6);
        drain();
        keep_src = {'1, '1};
        send_pkt(5'd4, 3'd3, 32'd10, 2);
        drain();
        keep_src = {'1, '1, '1, '1, 64'hFF};
        send_pkt(5'd1, 3'd4, 32'd11, 5);
        drain();

        // Buffer exactly full is still forwarded.
        keep_src = {'1, 64'h3, '1, 64'h8000_0000_0000_0000};
        send_pkt(5'd31, 3'd7, 32'd12, 4);
        drain();

        // Alternating backpressure over a four-beat packet.
        rdy_mode = 1;
        keep_src = {'1, '1, '1, 64'hFFFF};
        send_pkt(5'd12, 3'd5, 32'd13, 4);
        drain();
        rdy_mode = 0;

        // Empty-keep beats count as zero bytes.
        keep_src = {64'h0, 64'h0};
        send_pkt(5'd7, 3'd0, 32'd14, 2);
        drain();

        // Reset in the middle of a packet.
        keep_src = {'1, '1, '1, '1};
        send_pkt(5'd2, 3'd2, 32'd15, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_drops = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("midrst_tvalid", DW'(m_tvalid), DW'(0));
        check("midrst_tready", DW'(s_tready), DW'(1));
        check("midrst_drop_count", DW'(drop_count), DW'(0));
        keep_src = {64'hF};
        send_pkt(5'd6, 3'd3, 32'd16, 1);
        drain();

        // Timestamp field sample.
        keep_src = {'1, 64'h7};
        send_pkt(5'd10, 3'd1, 32'd1000, 2);
        drain();

        for (int p = 0; p < 30; p++) begin
            rdy_mode = $urandom_range(0, 2);
            nb = $urandom_range(1, DEPTH + 2);
            keep_src = {};
            for (int b = 0; b < nb; b++) keep_src.push_back(rand_keep());
            send_pkt(5'($urandom), DESTW'($urandom), $urandom, nb);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
